adder_seq_ctrl: RTL and testbench

Multi-cycle controller that performs an M-bit addition (M = N·K) by time-sharing a single N-bit `adder_N` slice over K clock cycles, least-significant slice first. A registered carry links each slice to the next. The block sits between a requester, which uses a start/ready/done handshake, and the shared N-bit adder datapath. It replaces K cascaded adder instances with one adder plus sequencing logic.

---
 rtl/adder_seq_pkg.sv | 20 ++
 rtl/adder_N.sv | 14 +
 rtl/adder_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the sequential adder controller.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N = 4;
  localparam int DEF_K = 2;

  // Slice index width; a single-slice build still keeps a 1-bit counter.
  function automatic int idx_width(input int k);
    return $clog2((k > 1) ? k : 2);
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_K);

endpackage

// File: rtl/adder_N.sv
// Plain N-bit ripple adder slice, time-shared by adder_seq_ctrl.
module adder_N #(
  parameter int N = 4
) (
  output logic [N-1:0] Y,
  output logic         Cout,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin
);

  assign {Cout, Y} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// M-bit adder built from one N-bit slice stepped over K cycles, LSB slice first.
// Optional signed-overflow output is enabled by defining ADDER_SEQ_OVF_EN.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = DEF_K,
  parameter int M = N * K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic         Cin,
  output logic         ready,
  output logic         done,
  output logic [M-1:0] Y,
  output logic         Cout
`ifdef ADDER_SEQ_OVF_EN
  , output logic       ovf
`endif
);

  localparam int IDX_W = idx_width(K);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [M-1:0]       aop_q, aop_d;
  logic [M-1:0]       bop_q, bop_d;
  logic [M-1:0]       y_q, y_d;
  logic               cout_q, cout_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
`ifdef ADDER_SEQ_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [N-1:0]       a_slice_s, b_slice_s, sum_s;
  logic               cout_s;

  assign a_slice_s = aop_q[idx_q*N +: N];
  assign b_slice_s = bop_q[idx_q*N +: N];

  adder_N #(.N(N)) u_slice (
    .Y    (sum_s),
    .Cout (cout_s),
    .A    (a_slice_s),
    .B    (b_slice_s),
    .Cin  (carry_q)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    aop_d   = aop_q;
    bop_d   = bop_q;
    y_d     = y_q;
    cout_d  = cout_q;
    ready_d = ready_q;
    done_d  = 1'b0;
`ifdef ADDER_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          aop_d   = A;
          bop_d   = B;
          carry_d = Cin;
          idx_d   = '0;
          ready_d = 1'b0;
          state_d = RUN;
        end else begin
          ready_d = 1'b1;
        end
      end
      RUN: begin
        y_d[idx_q*N +: N] = sum_s;
        carry_d           = cout_s;
        if (idx_q == IDX_W'(K - 1)) begin
          cout_d  = cout_s;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef ADDER_SEQ_OVF_EN
          // Top slice sum bit N-1 is the final Y[M-1].
          ovf_d   = (aop_q[M-1] == bop_q[M-1]) && (sum_s[N-1] != aop_q[M-1]);
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      aop_q   <= '0;
      bop_q   <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      aop_q   <= aop_d;
      bop_q   <= bop_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign Y     = y_q;
  assign Cout  = cout_q;
`ifdef ADDER_SEQ_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl (N=4, K=2): driver pushes expected sums,
// a negedge monitor pops and compares on every done pulse.
module tb_adder_seq_ctrl;

  localparam int N = 4;
  localparam int K = 2;
  localparam int M = N * K;

  typedef struct {
    logic [M:0] sum;
    logic       ovf;
    int         due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [M-1:0] A, B;
  logic         Cin;
  logic         ready, done;
  logic [M-1:0] Y;
  logic         Cout;
`ifdef ADDER_SEQ_OVF_EN
  logic         ovf;
`endif

  exp_t sb[$];
  int   done_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

  adder_seq_ctrl #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .ready (ready),
    .done  (done),
    .Y     (Y),
    .Cout  (Cout)
`ifdef ADDER_SEQ_OVF_EN
    , .ovf (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the full operands.
  function automatic exp_t model(input int a, input int b, input int cin, input int due);
    exp_t e;
    int   s, sa, sb_v;
    s     = a + b + cin;
    e.sum = (M+1)'(s);
    sa    = (a >= (1 << (M-1))) ? a - (1 << M) : a;
    sb_v  = (b >= (1 << (M-1))) ? b - (1 << M) : b;
    s     = sa + sb_v + cin;
    e.ovf = (s > (1 << (M-1)) - 1) || (s < -(1 << (M-1)));
    e.due = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      check("done_width", {31'd0, done_prev}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", {23'd0, Cout, Y}, {23'd0, e.sum});
        check("latency", cyc, e.due);
`ifdef ADDER_SEQ_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
      end
      done_cyc.push_back(cyc);
    end
    done_prev = done;
  end

  // Called at a negedge; waits for ready, presents one request for one cycle.
  task automatic issue(input int a, input int b, input int cin);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    A = M'(a); B = M'(b); Cin = cin[0]; start = 1'b1;
    sb.push_back(model(a, b, cin, cyc + 1 + K));
    @(negedge clk);
    start = 1'b0;
    A = M'($urandom); B = M'($urandom); Cin = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int vals[4] = '{0, 255, 128, 127};
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_y", {24'd0, Y}, 32'd0);
    check("rst_cout", {31'd0, Cout}, 32'd0);
    repeat (2) @(negedge clk);

    issue(8'hFF, 8'h01, 0);
    drain();
    issue(8'h37, 8'h48, 1);
    drain();

    // Held start; A changes during RUN and the second accept takes the new A.
    A = 8'h5A; B = 8'h21; Cin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h5A, 8'h21, 0, cyc + 1 + K));
    @(negedge clk);
    A = 8'h00;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held_ready", {31'd0, ready}, 32'd1);
    sb.push_back(model(8'h00, 8'h21, 0, cyc + 1 + K));
    @(negedge clk);
    start = 1'b0;
    drain();
    if (done_cyc.size() >= 2)
      check("b2b_gap", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 32'd4);
    else
      check("b2b_count", done_cyc.size(), 32'd2);

    // Reset in the first RUN cycle: no done must follow (monitor flags any).
    A = 8'hAA; B = 8'h55; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_y", {24'd0, Y}, 32'd0);
    check("mid_rst_cout", {31'd0, Cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(8'h12, 8'h34, 0);
    drain();

    foreach (vals[i]) foreach (vals[j]) for (int c = 0; c < 2; c++)
      issue(vals[i], vals[j], c);
    for (int t = 0; t < 3000; t++)
      issue(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
